// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types only). Backpressure: n/a.
package pipe_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_WAIT  = 2'd1,
    MISS_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Load-use comparator for one EX source operand against both MEM-stage producers.
// Latency: combinational. Backpressure: none; the hit feeds the interlock FSM.
module hazard_match
  import pipe_pkg::*;
(
  input  logic      ex_valid,
  input  logic      rf_re,
  input  reg_addr_t raddr,
  input  reg_addr_t mem_waddr_a,
  input  logic      mem_we_a,
  input  logic      mem_late_a,
  input  reg_addr_t mem_waddr_b,
  input  logic      mem_we_b,
  input  logic      mem_late_b,
  output logic      hit
);

  logic src_live;
  logic hit_a;
  logic hit_b;

  // r0 is hardwired, so a read of it can never depend on a producer.
  assign src_live = ex_valid && rf_re && (raddr != REG_ZERO);
  assign hit_a    = mem_we_a && mem_late_a && (raddr == mem_waddr_a);
  assign hit_b    = mem_we_b && mem_late_b && (raddr == mem_waddr_b);
  assign hit      = src_live && (hit_a || hit_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Dual-issue interlock: load-use stall, divider wait and D-cache miss wait; HAZARD_PERF_CNT_EN adds counters.
// Latency: outputs combinational from state and inputs. Backpressure: stall_front holds IF/ID/EX, stall_mem holds EX/MEM.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic      clk,
  input  logic      rstn,
  input  reg_addr_t EX_rf_raddr_a1,
  input  reg_addr_t EX_rf_raddr_a2,
  input  reg_addr_t EX_rf_raddr_b1,
  input  reg_addr_t EX_rf_raddr_b2,
  input  logic      EX_rf_re_a1,
  input  logic      EX_rf_re_a2,
  input  logic      EX_rf_re_b1,
  input  logic      EX_rf_re_b2,
  input  logic      EX_valid_a,
  input  logic      EX_valid_b,
  input  reg_addr_t MEM_rf_waddr_a,
  input  reg_addr_t MEM_rf_waddr_b,
  input  logic      MEM_rf_we_a,
  input  logic      MEM_rf_we_b,
  input  logic      MEM_late_a,
  input  logic      MEM_late_b,
  input  logic      EX_div_req,
  input  logic      div_done,
  input  logic      MEM_dcache_req,
  input  logic      dcache_ready,
  input  logic      flush,
  output logic      stall_front,
  output logic      bubble_mem,
  output logic      stall_mem,
  output logic      div_cancel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_lu_cnt,
  output logic [CNT_W-1:0] perf_div_cnt,
  output logic [CNT_W-1:0] perf_miss_cnt
`endif
);

  hz_state_t state_q, state_d;
  logic [3:0] src_hit;
  logic       lu;
  logic       miss_start;
  logic       div_start;

  hazard_match u_match_a1 (
    .ex_valid(EX_valid_a), .rf_re(EX_rf_re_a1), .raddr(EX_rf_raddr_a1),
    .mem_waddr_a(MEM_rf_waddr_a), .mem_we_a(MEM_rf_we_a), .mem_late_a(MEM_late_a),
    .mem_waddr_b(MEM_rf_waddr_b), .mem_we_b(MEM_rf_we_b), .mem_late_b(MEM_late_b),
    .hit(src_hit[0])
  );

  hazard_match u_match_a2 (
    .ex_valid(EX_valid_a), .rf_re(EX_rf_re_a2), .raddr(EX_rf_raddr_a2),
    .mem_waddr_a(MEM_rf_waddr_a), .mem_we_a(MEM_rf_we_a), .mem_late_a(MEM_late_a),
    .mem_waddr_b(MEM_rf_waddr_b), .mem_we_b(MEM_rf_we_b), .mem_late_b(MEM_late_b),
    .hit(src_hit[1])
  );

  hazard_match u_match_b1 (
    .ex_valid(EX_valid_b), .rf_re(EX_rf_re_b1), .raddr(EX_rf_raddr_b1),
    .mem_waddr_a(MEM_rf_waddr_a), .mem_we_a(MEM_rf_we_a), .mem_late_a(MEM_late_a),
    .mem_waddr_b(MEM_rf_waddr_b), .mem_we_b(MEM_rf_we_b), .mem_late_b(MEM_late_b),
    .hit(src_hit[2])
  );

  hazard_match u_match_b2 (
    .ex_valid(EX_valid_b), .rf_re(EX_rf_re_b2), .raddr(EX_rf_raddr_b2),
    .mem_waddr_a(MEM_rf_waddr_a), .mem_we_a(MEM_rf_we_a), .mem_late_a(MEM_late_a),
    .mem_waddr_b(MEM_rf_waddr_b), .mem_we_b(MEM_rf_we_b), .mem_late_b(MEM_late_b),
    .hit(src_hit[3])
  );

  assign lu         = |src_hit;
  assign miss_start = MEM_dcache_req && !dcache_ready;
  assign div_start  = EX_div_req && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Outputs are forced low while reset is held so an in-flight wait releases immediately.
  always_comb begin
    state_d     = state_q;
    stall_front = 1'b0;
    bubble_mem  = 1'b0;
    stall_mem   = 1'b0;
    div_cancel  = 1'b0;
    if (rstn) begin
      unique case (state_q)
        RUN: begin
          if (miss_start) begin
            state_d     = MISS_WAIT;
            stall_front = 1'b1;
            stall_mem   = 1'b1;
          end else if (div_start) begin
            state_d     = DIV_WAIT;
            stall_front = 1'b1;
            bubble_mem  = 1'b1;
          end else if (lu) begin
            stall_front = 1'b1;
            bubble_mem  = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (div_done) begin
            state_d = RUN;
          end else begin
            stall_front = 1'b1;
            bubble_mem  = 1'b1;
            if (flush) begin
              state_d    = RUN;
              div_cancel = 1'b1;
            end
          end
        end
        MISS_WAIT: begin
          // Flush is ignored here: the outstanding memory op is older than the branch.
          if (dcache_ready) begin
            state_d = RUN;
          end else begin
            stall_front = 1'b1;
            stall_mem   = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic lu_stall;
  assign lu_stall = (state_q == RUN) && !miss_start && !div_start && lu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_lu_cnt   <= '0;
      perf_div_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (lu_stall && perf_lu_cnt != CNT_MAX)
        perf_lu_cnt <= perf_lu_cnt + CNT_ONE;
      if (state_q == DIV_WAIT && perf_div_cnt != CNT_MAX)
        perf_div_cnt <= perf_div_cnt + CNT_ONE;
      if (state_q == MISS_WAIT && perf_miss_cnt != CNT_MAX)
        perf_miss_cnt <= perf_miss_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan scenarios, then randomized traffic
// checked each cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W  = 32;
  localparam int M_RUN  = 0;
  localparam int M_DIV  = 1;
  localparam int M_MISS = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] raddr [4];
  logic       re    [4];
  logic       ex_valid [2];
  logic [4:0] mwaddr [2];
  logic       mwe   [2];
  logic       mlate [2];
  logic       div_req, div_done, dc_req, dc_ready, flush;
  logic       stall_front, bubble_mem, stall_mem, div_cancel;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_lu_cnt, perf_div_cnt, perf_miss_cnt;
`endif

  int  n_cmp = 0;
  int  n_bad = 0;
  int  mode;
  longint m_lu_cnt, m_div_cnt, m_miss_cnt;
  logic obs_sf, obs_bm, obs_sm, obs_dc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .EX_rf_raddr_a1(raddr[0]), .EX_rf_raddr_a2(raddr[1]),
    .EX_rf_raddr_b1(raddr[2]), .EX_rf_raddr_b2(raddr[3]),
    .EX_rf_re_a1(re[0]), .EX_rf_re_a2(re[1]), .EX_rf_re_b1(re[2]), .EX_rf_re_b2(re[3]),
    .EX_valid_a(ex_valid[0]), .EX_valid_b(ex_valid[1]),
    .MEM_rf_waddr_a(mwaddr[0]), .MEM_rf_waddr_b(mwaddr[1]),
    .MEM_rf_we_a(mwe[0]), .MEM_rf_we_b(mwe[1]),
    .MEM_late_a(mlate[0]), .MEM_late_b(mlate[1]),
    .EX_div_req(div_req), .div_done(div_done),
    .MEM_dcache_req(dc_req), .dcache_ready(dc_ready), .flush(flush),
    .stall_front(stall_front), .bubble_mem(bubble_mem),
    .stall_mem(stall_mem), .div_cancel(div_cancel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lu_cnt(perf_lu_cnt), .perf_div_cnt(perf_div_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Any live source in either lane that reads the destination of a late MEM producer.
  function automatic bit model_lu();
    for (int s = 0; s < 4; s++) begin
      if (ex_valid[s/2] && re[s] && raddr[s] != 5'd0)
        for (int p = 0; p < 2; p++)
          if (mwe[p] && mlate[p] && mwaddr[p] == raddr[s]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_idle();
    for (int i = 0; i < 4; i++) begin raddr[i] = 5'd0; re[i] = 1'b0; end
    for (int i = 0; i < 2; i++) begin
      ex_valid[i] = 1'b0; mwaddr[i] = 5'd0; mwe[i] = 1'b0; mlate[i] = 1'b0;
    end
    div_req = 1'b0; div_done = 1'b0; dc_req = 1'b0; dc_ready = 1'b0; flush = 1'b0;
  endtask

  // One cycle: settle, compare against the model, then clock the model forward.
  task automatic tick();
    bit e_sf, e_bm, e_sm, e_dc, lu_inc;
    int nxt;
    #2;
    e_sf = 0; e_bm = 0; e_sm = 0; e_dc = 0; lu_inc = 0; nxt = mode;
    if (mode == M_RUN) begin
      if (dc_req && !dc_ready) begin e_sf = 1; e_sm = 1; nxt = M_MISS; end
      else if (div_req && !flush) begin e_sf = 1; e_bm = 1; nxt = M_DIV; end
      else if (model_lu()) begin e_sf = 1; e_bm = 1; lu_inc = 1; end
    end else if (mode == M_DIV) begin
      if (div_done) nxt = M_RUN;
      else if (flush) begin e_sf = 1; e_bm = 1; e_dc = 1; nxt = M_RUN; end
      else begin e_sf = 1; e_bm = 1; end
    end else begin
      if (dc_ready) nxt = M_RUN;
      else begin e_sf = 1; e_sm = 1; end
    end
    check_val("stall_front", stall_front, e_sf);
    check_val("bubble_mem",  bubble_mem,  e_bm);
    check_val("stall_mem",   stall_mem,   e_sm);
    check_val("div_cancel",  div_cancel,  e_dc);
`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_lu_cnt",   perf_lu_cnt,   m_lu_cnt);
    check_val("perf_div_cnt",  perf_div_cnt,  m_div_cnt);
    check_val("perf_miss_cnt", perf_miss_cnt, m_miss_cnt);
`endif
    obs_sf = stall_front; obs_bm = bubble_mem; obs_sm = stall_mem; obs_dc = div_cancel;
    @(posedge clk);
    #1;
    if (lu_inc) m_lu_cnt++;
    if (mode == M_DIV) m_div_cnt++;
    if (mode == M_MISS) m_miss_cnt++;
    mode = nxt;
  endtask

  task automatic set_load_use();
    mwaddr[0] = 5'd5; mwe[0] = 1'b1; mlate[0] = 1'b1;
    ex_valid[1] = 1'b1; re[2] = 1'b1; raddr[2] = 5'd5;
  endtask

  task automatic drive_random();
    for (int i = 0; i < 4; i++) begin
      raddr[i] = 5'($urandom_range(0, 3));
      re[i] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 2; i++) begin
      ex_valid[i] = ($urandom_range(0, 4) != 0);
      mwaddr[i] = 5'($urandom_range(0, 3));
      mwe[i] = (mwaddr[i] != 5'd0) && ($urandom_range(0, 3) != 0);
      mlate[i] = $urandom_range(0, 1) != 0;
    end
    div_req  = ($urandom_range(0, 9) == 0);
    div_done = ($urandom_range(0, 6) == 0);
    flush    = ($urandom_range(0, 9) == 0);
    dc_req   = ($urandom_range(0, 6) == 0);
    dc_ready = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int c_sf, c_sm, c_bm, c_dc;
    set_idle();
    rstn = 1'b0;
    mode = M_RUN; m_lu_cnt = 0; m_div_cnt = 0; m_miss_cnt = 0;
    set_load_use();
    dc_req = 1'b1;
    #12;
    check_val("rst_stall_front", stall_front, 0);
    check_val("rst_bubble_mem",  bubble_mem,  0);
    check_val("rst_stall_mem",   stall_mem,   0);
    check_val("rst_div_cancel",  div_cancel,  0);
    set_idle();
    #3 rstn = 1'b1;
    @(posedge clk); #1;

    // Load-use: one-cycle stall, then the producer has moved to WB.
    set_load_use();
    tick();
    check_val("lu_stall", obs_sf, 1);
    check_val("lu_bubble", obs_bm, 1);
    mlate[0] = 1'b0; mwe[0] = 1'b0;
    tick();
    check_val("lu_release", obs_sf, 0);
    set_load_use(); mlate[0] = 1'b0;
    tick();
    check_val("alu_no_stall", obs_sf, 0);
    set_load_use(); mwaddr[0] = 5'd0; mwe[0] = 1'b0; raddr[2] = 5'd0;
    tick();
    check_val("r0_no_stall", obs_sf, 0);
    set_idle();

    // Divide: launch plus six wait cycles, done arrives on the seventh.
    c_sf = 0; c_dc = 0;
    div_req = 1'b1;
    tick(); c_sf += obs_sf;
    div_req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      div_done = (k == 7);
      tick(); c_sf += obs_sf; c_dc += obs_dc;
    end
    div_done = 1'b0;
    check_val("div_stall_cycles", c_sf, 7);
    check_val("div_no_cancel", c_dc, 0);
    tick();
    check_val("div_back_to_run", obs_sf, 0);

    // Flush on the third wait cycle cancels the divide.
    div_req = 1'b1; tick(); div_req = 1'b0;
    tick(); tick();
    flush = 1'b1; tick();
    check_val("flush_cancel", obs_dc, 1);
    check_val("flush_cycle_stall", obs_sf, 1);
    flush = 1'b0; tick();
    check_val("flush_stall_drop", obs_sf, 0);
    check_val("flush_cancel_drop", obs_dc, 0);

    // Flush and done together: done wins.
    div_req = 1'b1; tick(); div_req = 1'b0;
    tick(); tick();
    flush = 1'b1; div_done = 1'b1; tick();
    check_val("done_flush_cancel", obs_dc, 0);
    check_val("done_flush_stall", obs_sf, 0);
    set_idle();

    // Miss with a coincident load-use: lu masked until the wait ends.
    set_load_use();
    dc_req = 1'b1;
    c_sf = 0; c_sm = 0; c_bm = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); c_sf += obs_sf; c_sm += obs_sm; c_bm += obs_bm;
    end
    check_val("miss_stall_front", c_sf, 10);
    check_val("miss_stall_mem", c_sm, 10);
    check_val("miss_no_bubble", c_bm, 0);
    dc_ready = 1'b1; tick();
    check_val("miss_ready_drop", {obs_sf, obs_sm, obs_bm}, 3'b000);
    dc_req = 1'b0; dc_ready = 1'b0; tick();
    check_val("post_miss_lu", {obs_sf, obs_bm, obs_sm}, 3'b110);
    set_idle(); tick();
    check_val("post_miss_release", obs_sf, 0);

    // Asynchronous reset in the middle of a miss wait.
    dc_req = 1'b1; tick(); tick();
    #2 rstn = 1'b0;
    #1;
    check_val("arst_outputs", {stall_front, bubble_mem, stall_mem, div_cancel}, 4'b0000);
`ifdef HAZARD_PERF_CNT_EN
    check_val("arst_lu_cnt", perf_lu_cnt, 0);
    check_val("arst_div_cnt", perf_div_cnt, 0);
    check_val("arst_miss_cnt", perf_miss_cnt, 0);
`endif
    set_idle();
    mode = M_RUN; m_lu_cnt = 0; m_div_cnt = 0; m_miss_cnt = 0;
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
